fifo_symbol_packer: RTL

- Read-side consumer for the 8-deep, 3-bit synchronous FIFO.
- Pops 3-bit symbols through the FIFO's empty/rd_en/data interface and packs PACK consecutive symbols into one wide word, LSB-first.
- Presents each word downstream on a valid/ready handshake.
- A flush request emits a partial word carrying a symbol count.

---
 rtl/fifo_symbol_packer.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/fifo_symbol_packer.sv
// -----------------------------------------------------------------------------
// fifo_symbol_packer
//
// Read-side consumer for a small synchronous FIFO. It pops DATA_W-bit symbols
// and packs PACK consecutive symbols LSB-first into one wide word. Each word is
// offered downstream on a valid/ready handshake. A flush request emits the
// partial word, with a count of how many symbols it holds.
//
// The FIFO registers its read data. A symbol popped in cycle N therefore
// appears on fifo_data_i in cycle N+1. pop_q tracks that in-flight pop.
//
// Ports
//   clk           clock; all state updates on the rising edge
//   reset_i       asynchronous active-low reset
//   fifo_empty_i  FIFO empty flag
//   fifo_data_i   FIFO read data, valid the cycle after a pop
//   fifo_rd_en_o  pop request to the FIFO (combinational)
//   flush_i       single-cycle request to emit the partial word
//   word_o        packed word; symbol k at bits [k*DATA_W +: DATA_W]
//   word_cnt_o    number of valid symbols in word_o (1..PACK)
//   word_valid_o  word_o / word_cnt_o valid
//   word_ready_i  downstream accept
// -----------------------------------------------------------------------------
module fifo_symbol_packer #(
  parameter int DATA_W = 3,
  parameter int PACK   = 4   // symbols per word, 2..8
) (
  input  logic                     clk,
  input  logic                     reset_i,
  input  logic                     fifo_empty_i,
  input  logic [DATA_W-1:0]        fifo_data_i,
  output logic                     fifo_rd_en_o,
  input  logic                     flush_i,
  output logic [DATA_W*PACK-1:0]   word_o,
  output logic [3:0]               word_cnt_o,
  output logic                     word_valid_o,
  input  logic                     word_ready_i
);

  localparam int         WORD_W    = DATA_W * PACK;
  localparam logic [3:0] PACK_CNT  = 4'(PACK);
  localparam logic [3:0] LAST_SLOT = 4'(PACK - 1);

  // acc has PACK slots. Under backpressure it can fill completely
  // (acc_cnt == PACK) while the output register still holds the previous word.
  logic [PACK-1:0][DATA_W-1:0] acc;
  logic [PACK-1:0][DATA_W-1:0] acc_masked;
  logic [3:0]                  acc_cnt;
  logic                        pop_q;
  logic                        flush_pend;

  logic                        out_free;
  logic                        full_capture;
  logic                        deferred_move;
  logic                        flush_emit;
  logic                        load;
  logic [WORD_W-1:0]           load_word;
  logic [3:0]                  load_cnt;

  // Control decode.
  always_comb begin
    // Pop only when a slot is guaranteed for the symbol. A symbol already in
    // flight (pop_q) has a slot reserved, so it counts against the space.
    // The FIFO does not guard against underflow, so never pop while it is empty.
    fifo_rd_en_o  = !fifo_empty_i && !flush_pend &&
                    ((acc_cnt + {3'b000, pop_q}) < PACK_CNT);

    out_free      = !word_valid_o || word_ready_i;

    // The last symbol of a word goes straight from the FIFO to the output.
    // This avoids a pass through acc.
    full_capture  = pop_q && (acc_cnt == LAST_SLOT) && out_free;

    // A word that filled up under backpressure moves out once the output frees.
    deferred_move = !pop_q && (acc_cnt == PACK_CNT) && out_free;

    // A flush waits for any in-flight symbol to land, so that symbol is included.
    flush_emit    = !pop_q && flush_pend && (acc_cnt != 4'd0) && out_free;

    load          = full_capture || deferred_move || flush_emit;
  end

  // Word assembly. Slots at or above acc_cnt may hold stale symbols from an
  // earlier word. They are zeroed so that a partial word has clean upper bits.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    acc_masked = '0;
    for (int k = 0; k < PACK; k++) begin
      if (4'(k) < acc_cnt) acc_masked[k] = acc[k];
    end
    load_word = acc_masked;
    load_cnt  = acc_cnt;
    if (full_capture) begin
      load_word = {fifo_data_i, acc_masked[PACK-2:0]};
      load_cnt  = PACK_CNT;
    end
  end

  // Accumulator, pop tracking and flush state.
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      // NOTE: acc is a handful of flops, not a RAM, so it is reset along with
      // everything else. A RAM-sized store would be left unreset.
      acc        <= '0;
      acc_cnt    <= 4'd0;
      pop_q      <= 1'b0;
      flush_pend <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // right-hand side here sees the values from before this edge.
      pop_q <= fifo_rd_en_o;

      if (load) begin
        acc_cnt <= 4'd0;
      end else if (pop_q) begin
        for (int k = 0; k < PACK; k++) begin
          if (4'(k) == acc_cnt) acc[k] <= fifo_data_i;
        end
        acc_cnt <= acc_cnt + 4'd1;
      end

      // A flush request that arrives while one is pending is ignored.
      if (flush_pend) begin
        if (!pop_q && ((acc_cnt == 4'd0) || flush_emit)) flush_pend <= 1'b0;
      end else if (flush_i) begin
        flush_pend <= 1'b1;
      end
    end
  end

  // Output register. A load has priority over an accept, so that a back-to-back
  // word keeps valid high. Without a load the word holds until it is accepted.
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      word_o       <= '0;
      word_cnt_o   <= 4'd0;
      word_valid_o <= 1'b0;
    end else if (load) begin
      word_o       <= load_word;
      word_cnt_o   <= load_cnt;
      word_valid_o <= 1'b1;
    end else if (word_ready_i) begin
      word_valid_o <= 1'b0;
    end
  end

endmodule
